seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 63 ++++++
 tb/tb_seq_detect_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: configurable serial pattern detector with overlap control and saturating match counter
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 16,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               a,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);
    logic [MAX_LEN-1:0] pat, hist, mask, cand;
    logic [LW-1:0] len, fill, last;
    logic ovl, accept, cfg_ok, full, match;

    // compare the candidate word against the active pattern, masked to the active length
    always_comb begin
        last = len - LW'(1);
        cand = {hist[MAX_LEN-2:0], a};
        mask = ~({MAX_LEN{1'b1}} << len);
        accept = in_valid && !cfg_load && !reset;
        cfg_ok = cfg_len >= LW'(2) && cfg_len <= LW'(MAX_LEN);
        full = fill == last;
        match = accept && full && ((cand ^ pat) & mask) == '0;
        y = match;
    end

    // configuration load has priority over samples; fill restarts after a non-overlapping match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat <= MAX_LEN'(4'b1101);
            len <= LW'(4);
            ovl <= 1'b1;
            hist <= '0;
            fill <= '0;
            match_count <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            if (cfg_ok) begin
                pat <= cfg_pattern;
                len <= cfg_len;
                ovl <= cfg_overlap;
                hist <= '0;
                fill <= '0;
                match_count <= '0;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end else if (in_valid) begin
            hist <= cand;
            fill <= match ? (ovl ? fill : '0) : (full ? fill : fill + LW'(1));
            if (match && match_count != '1) match_count <= match_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param, default and 2-bit counter instances
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic reset, cfg_load, cfg_overlap, in_valid, a;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic y, y2, cfg_err, cfg_err2;
    logic [15:0] mc;
    logic [1:0] mc2;

    typedef struct {
        logic y;
        int   c16;
        int   c2;
        logic err;
    } exp_t;
    exp_t sb[$];

    logic [7:0]  m_pat;
    int          m_len, m_since, m_c16, m_c2;
    logic        m_ovl, m_err;
    logic [63:0] m_hist;
    int checks = 0;
    int errors = 0;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .a(a),
        .y(y), .match_count(mc), .cfg_err(cfg_err)
    );

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .a(a),
        .y(y2), .match_count(mc2), .cfg_err(cfg_err2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset;
        m_pat = 8'b1101;
        m_len = 4;
        m_ovl = 1'b1;
        m_hist = '0;
        m_since = 0;
        m_c16 = 0;
        m_c2 = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic ld, input logic [7:0] p, input logic [3:0] l,
                              input logic o, input logic v, input logic b, output logic ym);
        logic [63:0] h, mk;
        ym = 1'b0;
        if (ld) begin
            if (l >= 2 && l <= 8) begin
                m_pat = p;
                m_len = int'(l);
                m_ovl = o;
                m_hist = '0;
                m_since = 0;
                m_c16 = 0;
                m_c2 = 0;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            h = {m_hist[62:0], b};
            mk = (64'd1 << m_len) - 64'd1;
            m_hist = h;
            m_since++;
            if (m_since >= m_len && (h & mk) == ({56'd0, m_pat} & mk)) begin
                ym = 1'b1;
                if (m_c16 < 65535) m_c16++;
                if (m_c2 < 3) m_c2++;
                if (!m_ovl) m_since = 0;
            end
        end
    endtask

    task automatic step(input string tag, input logic ld, input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic v, input logic b);
        exp_t e, g;
        @(negedge clk);
        cfg_load = ld;
        cfg_pattern = p;
        cfg_len = l;
        cfg_overlap = o;
        in_valid = v;
        a = b;
        model_step(ld, p, l, o, v, b, e.y);
        e.c16 = m_c16;
        e.c2 = m_c2;
        e.err = m_err;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check({tag, "_y"}, 32'(y), 32'(g.y));
        check({tag, "_y2"}, 32'(y2), 32'(g.y));
        @(posedge clk);
        #1;
        check({tag, "_cnt"}, 32'(mc), 32'(g.c16));
        check({tag, "_cnt2"}, 32'(mc2), 32'(g.c2));
        check({tag, "_err"}, 32'(cfg_err), 32'(g.err));
        check({tag, "_err2"}, 32'(cfg_err2), 32'(g.err));
    endtask

    task automatic vbit(input string tag, input logic b);
        step(tag, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b);
    endtask

    task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l, input logic o);
        step(tag, 1'b1, p, l, o, 1'b1, 1'b1);
    endtask

    task automatic stream(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) vbit(tag, bits[i]);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        cfg_load = 1'b0;
        in_valid = 1'b1;
        a = 1'b1;
        model_reset;
        #1;
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_y2"}, 32'(y2), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_cnt"}, 32'(mc), 32'd0);
        check({tag, "_err"}, 32'(cfg_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cfg_load = 1'b0;
        cfg_pattern = '0;
        cfg_len = '0;
        cfg_overlap = 1'b0;
        in_valid = 1'b0;
        a = 1'b0;
        model_reset;
        pulse_reset("rst");

        stream("ovl", 32'b1101101, 7);
        check("ovl_total", 32'(mc), 32'd2);

        load("ld_nov", 8'b1101, 4'd4, 1'b0);
        stream("nov", 32'b1101101, 7);
        check("nov_total", 32'(mc), 32'd1);

        load("ld_gap", 8'b1101, 4'd4, 1'b1);
        stream("gap", 32'b110, 3);
        for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'(i % 2 == 0));
        vbit("gap_last", 1'b1);
        check("gap_total", 32'(mc), 32'd1);

        load("bad0", 8'h00, 4'd0, 1'b0);
        check("bad0_flag", 32'(cfg_err), 32'd1);
        stream("old", 32'b1101, 4);
        check("old_total", 32'(mc), 32'd2);
        load("bad9", 8'hFF, 4'd9, 1'b0);
        check("bad9_flag", 32'(cfg_err), 32'd1);

        load("ld_sat", 8'hF3, 4'd2, 1'b1);
        check("ld_sat_clr", 32'(cfg_err), 32'd0);
        stream("sat", 32'b111111, 6);
        check("sat_c2", 32'(mc2), 32'd3);
        check("sat_c16", 32'(mc), 32'd5);

        load("ld_rst", 8'b1101, 4'd4, 1'b1);
        stream("pre", 32'b110, 3);
        pulse_reset("mid_rst");
        vbit("post", 1'b1);
        check("post_total", 32'(mc), 32'd0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset("rnd_rst");
            else if ($urandom_range(0, 24) == 0)
                step("rnd_ld", 1'b1, 8'($urandom), 4'($urandom_range(0, 5) == 0 ? $urandom_range(0, 10) : $urandom_range(2, 4)),
                     1'($urandom), 1'($urandom), 1'($urandom));
            else
                step("rnd", 1'b0, 8'h00, 4'd0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
